// File: rtl/vga_scan.sv
// vga_scan: parametrised VGA raster generator.
// Counts pixels (hc) and lines (vc) on pix_en ticks, presents the request
// coordinate to a pixel source, and delays the active/sync flags by
// LOOKAHEAD ticks so the returned colour lines up with its own timing.
// Every registered element advances only on pix_en=1 and is cleared by a
// synchronous active-low reset regardless of pix_en.
module vga_scan #(
    parameter int COLOR_BITS = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FPORCH   = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BPORCH   = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FPORCH   = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BPORCH   = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int LOOKAHEAD  = 1,
    parameter int COORD_W    = 16
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic                      pix_en,
    input  logic [3*COLOR_BITS-1:0]   color,
    output logic [COORD_W-1:0]        pix_x,
    output logic [COORD_W-1:0]        pix_y,
    output logic                      pix_req,
    output logic                      line_start,
    output logic                      frame_start,
    output logic [COLOR_BITS-1:0]     vga_r,
    output logic [COLOR_BITS-1:0]     vga_g,
    output logic [COLOR_BITS-1:0]     vga_b,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic                      blank
);

    localparam int H_TOTAL = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;

    // Elaboration-time sanity checks on the timing parameters.
    if (LOOKAHEAD < 0 || LOOKAHEAD > 7) begin : g_bad_lookahead
        $error("vga_scan: LOOKAHEAD must be in 0..7");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $error("vga_scan: sync pulse lengths must be non-zero");
    end
    if ((H_TOTAL >> COORD_W) != 0 || (V_TOTAL >> COORD_W) != 0) begin : g_bad_coord
        $error("vga_scan: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
    end

    // Boundaries as counter-width constants so all compares are same-width.
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FPORCH);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FPORCH + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FPORCH);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FPORCH + V_SYNC);
    localparam logic               HS_ON    = (HSYNC_POL != 0);
    localparam logic               VS_ON    = (VSYNC_POL != 0);

    logic [COORD_W-1:0]      hc;
    logic [COORD_W-1:0]      vc;
    logic                    active_raw;
    logic                    hs_raw;
    logic                    vs_raw;
    logic [2:0]              cur_flags;   // {active, hsync, vsync} of the request position
    logic [2:0]              tail;        // flags of the pixel being displayed now
    logic [3*COLOR_BITS-1:0] rgb;

    // Raster counters: hc wraps every line, vc steps on the hc wrap.
    always_ff @(posedge clk) begin
        if (!res) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + COORD_W'(1);
            end else begin
                hc <= hc + COORD_W'(1);
            end
        end
    end

    assign active_raw = (hc < H_ACT) && (vc < V_ACT);
    assign hs_raw     = (hc >= HS_START) && (hc < HS_END);
    assign vs_raw     = (vc >= VS_START) && (vc < VS_END);
    assign cur_flags  = {active_raw, hs_raw, vs_raw};

    // Request side is combinational so the pixel source sees it immediately.
    assign pix_x       = hc;
    assign pix_y       = vc;
    assign pix_req     = active_raw && res;
    assign line_start  = pix_en && res && (hc == '0);
    assign frame_start = pix_en && res && (hc == '0) && (vc == '0);

    // Flag delay line matching the pixel source latency.
    if (LOOKAHEAD == 0) begin : g_direct
        assign tail = cur_flags;
    end else begin : g_pipe
        logic [2:0] pipe [LOOKAHEAD];

        // Shift the flags one stage per pixel tick; reset clears to no-display.
        always_ff @(posedge clk) begin
            if (!res) begin
                for (int i = 0; i < LOOKAHEAD; i++) pipe[i] <= 3'b000;
            end else if (pix_en) begin
                pipe[0] <= cur_flags;
                for (int i = 1; i < LOOKAHEAD; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign tail = pipe[LOOKAHEAD-1];
    end

    // Output register: gate colour by the delayed active flag and apply polarity.
    always_ff @(posedge clk) begin
        if (!res) begin
            rgb       <= '0;
            blank     <= 1'b1;
            vga_hsync <= ~HS_ON;
            vga_vsync <= ~VS_ON;
        end else if (pix_en) begin
            rgb       <= tail[2] ? color : '0;
            blank     <= ~tail[2];
            vga_hsync <= tail[1] ? HS_ON : ~HS_ON;
            vga_vsync <= tail[0] ? VS_ON : ~VS_ON;
        end
    end

    assign vga_r = rgb[3*COLOR_BITS-1:2*COLOR_BITS];
    assign vga_g = rgb[2*COLOR_BITS-1:COLOR_BITS];
    assign vga_b = rgb[COLOR_BITS-1:0];

endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: bench for vga_scan on a small 14x7 raster, LOOKAHEAD=3,
// active-high syncs. The reference model treats the raster as a linear
// pixel index counted in enabled ticks since reset.
module tb_vga_scan;

    localparam int CB = 4;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HP = 1, VP = 1;
    localparam int LA = 3;
    localparam int CW = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic            clk;
    logic            res;
    logic            pix_en;
    logic [3*CB-1:0] color;
    logic [CW-1:0]   pix_x;
    logic [CW-1:0]   pix_y;
    logic            pix_req;
    logic            line_start;
    logic            frame_start;
    logic [CB-1:0]   vga_r;
    logic [CB-1:0]   vga_g;
    logic [CB-1:0]   vga_b;
    logic            vga_hsync;
    logic            vga_vsync;
    logic            blank;

    vga_scan #(
        .COLOR_BITS(CB),
        .H_ACTIVE(HA), .H_FPORCH(HF), .H_SYNC(HS), .H_BPORCH(HB),
        .V_ACTIVE(VA), .V_FPORCH(VF), .V_SYNC(VS), .V_BPORCH(VB),
        .HSYNC_POL(HP), .VSYNC_POL(VP),
        .LOOKAHEAD(LA), .COORD_W(CW)
    ) dut (
        .clk(clk), .res(res), .pix_en(pix_en), .color(color),
        .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
        .line_start(line_start), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .blank(blank)
    );

    // Clock and initial input values.
    initial begin
        clk    = 1'b0;
        res    = 1'b0;
        pix_en = 1'b0;
        color  = '0;
    end
    always #5 clk = ~clk;

    // Scoreboard state.
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    int              k_done   = 0;     // enabled ticks since last reset edge
    logic [3*CB-1:0] last_color = '0;  // colour presented on the last enabled tick
    logic [CW-1:0]   exp_q[$];         // emulated pixel source: requested x values in flight
    logic            hs_log[$];
    logic            vs_log[$];
    logic            fs_log[$];
    logic            ls_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Raster rules applied to a linear pixel index.
    function automatic bit px_active(input int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction
    function automatic bit px_hs(input int p);
        int x;
        x = p % HT;
        return (x >= HA + HF) && (x < HA + HF + HS);
    endfunction
    function automatic bit px_vs(input int p);
        int y;
        y = (p / HT) % VT;
        return (y >= VA + VF) && (y < VA + VF + VS);
    endfunction

    // Compare all outputs against the model for the current inputs.
    task automatic model_check();
        int x, y, p;
        bit act, hsn, vsn;
        x   = k_done % HT;
        y   = (k_done / HT) % VT;
        check("pix_x", pix_x, x);
        check("pix_y", pix_y, y);
        check("pix_req", pix_req, res && x < HA && y < VA);
        check("line_start", line_start, res && pix_en && x == 0);
        check("frame_start", frame_start, res && pix_en && x == 0 && y == 0);
        p   = k_done - 1 - LA;
        act = (p >= 0) && px_active(p);
        hsn = (p >= 0) && px_hs(p);
        vsn = (p >= 0) && px_vs(p);
        check("rgb", {vga_r, vga_g, vga_b}, act ? last_color : '0);
        check("blank", blank, !act);
        check("hsync", vga_hsync, hsn ? HP : 1 - HP);
        check("vsync", vga_vsync, vsn ? VP : 1 - VP);
    endtask

    // Pass one clock edge and update the model from the inputs it sampled.
    task automatic advance();
        @(posedge clk);
        if (!res) begin
            k_done = 0;
        end else if (pix_en) begin
            k_done++;
            last_color = color;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Driver: apply inputs, check, log, clock.
    task automatic drive_cycle(input logic r, input logic e, input logic [3*CB-1:0] c);
        res    = r;
        pix_en = e;
        color  = c;
        #1;
        model_check();
        hs_log.push_back(vga_hsync);
        vs_log.push_back(vga_vsync);
        fs_log.push_back(frame_start);
        ls_log.push_back(line_start);
        advance();
    endtask

    task automatic clear_logs();
        hs_log.delete();
        vs_log.delete();
        fs_log.delete();
        ls_log.delete();
    endtask

    // Check frame/line periods and sync pulse widths over one steady frame.
    task automatic check_periods(input string tag, input int frame_p, input int line_p,
                                 input int hs_cnt, input int vs_cnt);
        int fsi[$];
        int nh, nv, li;
        for (int i = 0; i < fs_log.size(); i++) if (fs_log[i]) fsi.push_back(i);
        check({tag, "_fs_seen"}, fsi.size() >= 3, 1);
        if (fsi.size() >= 3) begin
            check({tag, "_frame_period"}, fsi[2] - fsi[1], frame_p);
            li = -1;
            for (int i = fsi[1] + 1; i < ls_log.size() && li < 0; i++) if (ls_log[i]) li = i;
            check({tag, "_line_period"}, li - fsi[1], line_p);
            nh = 0;
            nv = 0;
            for (int i = fsi[1]; i < fsi[2]; i++) begin
                if (hs_log[i] == HP[0]) nh++;
                if (vs_log[i] == VP[0]) nv++;
            end
            check({tag, "_hsync_cycles"}, nh, hs_cnt);
            check({tag, "_vsync_cycles"}, nv, vs_cnt);
        end
    endtask

    typedef struct {
        logic            r;
        logic            e;
        logic [3*CB-1:0] c;
        int              x;
        int              y;
        logic            req;
        logic            ls;
        logic            fs;
        logic            blk;
        logic [3*CB-1:0] rgb;
        logic            hs;
        logic            vs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Directed table: first ticks after reset, a stall, a one-cycle reset.
        vecs[0] = '{1'b1, 1'b1, 12'h123, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 12'h456, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 12'h789, 2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 12'hABC, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 12'hDEF, 4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 12'h321, 4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 12'h654, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 12'h987, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0};

        // Reset held low with pix_en high.
        res    = 1'b0;
        pix_en = 1'b1;
        advance();
        advance();
        #1;
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_blank", blank, 1);
        check("rst_hsync", vga_hsync, 1 - HP);
        check("rst_vsync", vga_vsync, 1 - VP);
        check("rst_pix_req", pix_req, 0);
        check("rst_frame_start", frame_start, 0);

        for (int i = 0; i < 8; i++) begin
            res    = vecs[i].r;
            pix_en = vecs[i].e;
            color  = vecs[i].c;
            #1;
            check("tbl_pix_x", pix_x, vecs[i].x);
            check("tbl_pix_y", pix_y, vecs[i].y);
            check("tbl_pix_req", pix_req, vecs[i].req);
            check("tbl_line_start", line_start, vecs[i].ls);
            check("tbl_frame_start", frame_start, vecs[i].fs);
            check("tbl_blank", blank, vecs[i].blk);
            check("tbl_rgb", {vga_r, vga_g, vga_b}, vecs[i].rgb);
            check("tbl_hsync", vga_hsync, vecs[i].hs);
            check("tbl_vsync", vga_vsync, vecs[i].vs);
            advance();
        end

        // Continuous pixel ticks: periods and pulse widths.
        drive_cycle(1'b0, 1'b1, '0);
        clear_logs();
        for (int i = 0; i < 3 * HT * VT + 10; i++) drive_cycle(1'b1, 1'b1, 12'($urandom));
        check_periods("cont", HT * VT, HT, HS * VT, VS * HT);

        // pix_en alternating: everything stretches by two.
        drive_cycle(1'b0, 1'b1, '0);
        clear_logs();
        for (int i = 0; i < 6 * HT * VT + 20; i++) drive_cycle(1'b1, 1'((i + 1) % 2), 12'($urandom));
        check_periods("half", 2 * HT * VT, 2 * HT, 2 * HS * VT, 2 * VS * HT);

        // Emulated pixel source with LA ticks of latency returning x replicated.
        drive_cycle(1'b0, 1'b1, '0);
        exp_q.delete();
        for (int i = 0; i < 3 * HT * VT; i++) begin
            logic            e;
            logic [3*CB-1:0] c;
            logic [CW-1:0]   xr;
            e = ($urandom_range(0, 3) != 0);
            c = '0;
            if (e) begin
                exp_q.push_back(pix_x);
                if (exp_q.size() > LA) begin
                    xr = exp_q.pop_front();
                    c  = {xr[CB-1:0], xr[CB-1:0], xr[CB-1:0]};
                end
            end
            drive_cycle(1'b1, e, c);
        end

        // Random enables, colours and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            drive_cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0), 12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
